// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and
// small helpers used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Receive-side byte interface between the UART deserializer and its consumer.
interface uart_rx_deserializer_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    // Handshake: a byte transfers on every clk edge where rx_valid && rx_ready.
    // The master holds rx_data and the error flags stable while rx_valid is high
    // and the byte has not been taken; rx_ready may be driven independently of
    // rx_valid. overrun_err is a side-band 1-clk pulse outside the handshake.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start-bit qualification, mid-bit majority sampling, LSB-first
// shifting, parity/stop checking and a single-entry holding register.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_tick,
    input  logic                   rx_in,
    input  logic                   parity_en,
    input  logic                   parity_odd,
    uart_rx_deserializer_if.master rx_bus,
    output uart_state_t            dbg_state
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] T_PRE  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_RES  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state_q;
    uart_state_t          state_d;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [1:0]           smp_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 par_err_q;

    logic                 resolve;
    logic                 bit_end;
    logic                 bit_val;
    logic                 commit;

    logic [DATA_BITS-1:0] hold_data_q;
    logic                 hold_valid_q;
    logic                 hold_perr_q;
    logic                 hold_ferr_q;
    logic                 overrun_q;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    assign resolve = sample_tick && (tick_cnt_q == T_RES);
    assign bit_end = sample_tick && (tick_cnt_q == T_LAST);
    assign bit_val = majority3(smp_q[0], smp_q[1], rx_s);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick && !rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // A start bit that votes high at mid-bit was noise.
                if (resolve && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt_q == B_LAST)) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave at mid-stop so a start edge right after stop is not missed.
                if (resolve) begin
                    state_d = IDLE;
                    commit  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing, sampling and shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            smp_q      <= 2'b11;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_err_q  <= 1'b0;
        end else if (sample_tick) begin
            if (state_q == IDLE) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                if (!rx_s) begin
                    par_en_q  <= parity_en;
                    par_odd_q <= parity_odd;
                    par_err_q <= 1'b0;
                end
            end else begin
                tick_cnt_q <= (tick_cnt_q == T_LAST) ? '0 : tick_cnt_q + 1'b1;
                if (tick_cnt_q == T_PRE) begin
                    smp_q[0] <= rx_s;
                end
                if (tick_cnt_q == T_MID) begin
                    smp_q[1] <= rx_s;
                end
                // Right shift so the first bit received ends up in bit 0.
                if (resolve && (state_q == DATA)) begin
                    shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                end
                if (resolve && (state_q == PARITY)) begin
                    par_err_q <= ((^shift_q) ^ bit_val) != par_odd_q;
                end
                if ((state_q == DATA) && bit_end) begin
                    bit_cnt_q <= (bit_cnt_q == B_LAST) ? '0 : bit_cnt_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_perr_q  <= 1'b0;
            hold_ferr_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (commit) begin
                // A byte leaving in this same cycle frees the slot for the new one.
                if (!hold_valid_q || rx_bus.rx_ready) begin
                    hold_data_q  <= shift_q;
                    hold_valid_q <= 1'b1;
                    hold_perr_q  <= par_en_q & par_err_q;
                    hold_ferr_q  <= !bit_val;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (hold_valid_q && rx_bus.rx_ready) begin
                hold_valid_q <= 1'b0;
                hold_perr_q  <= 1'b0;
                hold_ferr_q  <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data     = hold_data_q;
    assign rx_bus.rx_valid    = hold_valid_q;
    assign rx_bus.parity_err  = hold_perr_q;
    assign rx_bus.frame_err   = hold_ferr_q;
    assign rx_bus.overrun_err = overrun_q;
    assign dbg_state          = state_q;

endmodule
